// File: rtl/column_pattern_scroller.sv
// Scrolling column-bitmap source for the flappy-bird playfield.
// Keeps a COLS-deep window of ROWS-bit columns (1 = wall, 0 = open). Each
// accepted step shifts the window toward column 0 and appends either an
// empty column or a pipe column whose opening comes from an 8-bit LFSR.
module column_pattern_scroller #(
  parameter int ROWS    = 16,
  parameter int COLS    = 8,
  parameter int GAP     = 4,
  parameter int SEL_W   = 3,
  parameter int SPACING = 3,
  parameter int PIPE_W  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     step,
  input  logic                     seed_load,
  input  logic [7:0]               seed,
  input  logic [$clog2(COLS)-1:0]  rd_col,
  output logic [ROWS-1:0]          rd_data,
  output logic [ROWS-1:0]          front_col,
  output logic [SEL_W-1:0]         gap_sel,
  output logic                     new_pipe,
  output logic                     passed
);

  localparam int IDX_W   = $clog2(COLS);
  localparam int CNT_MAX = (SPACING > PIPE_W) ? SPACING : PIPE_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SPACE_LAST = CNT_W'(SPACING - 1);
  localparam logic [CNT_W-1:0] PIPE_LAST  = CNT_W'(PIPE_W - 1);

  typedef enum logic {SPACE = 1'b0, PIPE = 1'b1} state_t;

  // Wall column with a GAP-row opening starting at row s.
  function automatic logic [ROWS-1:0] pipe_column(input logic [SEL_W-1:0] s);
    logic [ROWS-1:0] hole;
    hole = {{(ROWS-GAP){1'b0}}, {GAP{1'b1}}};
    return ~(hole << s);
  endfunction

  // One Fibonacci shift: taps 7,5,4,3 feed bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [SEL_W-1:0]  gap_sel_q, gap_sel_d;
  logic              new_pipe_q, new_pipe_d;
  logic              passed_q, passed_d;
  logic [ROWS-1:0]   ins_col;
  logic              ins_tag;
  logic              adv;

  logic [ROWS-1:0]   buf_q [COLS];
  logic [COLS-1:0]   tag_q;

  // A seed load takes the cycle; a step during it is dropped.
  assign adv = enable & step & ~seed_load;

  // Next-state: column generation, rhythm counter, LFSR and pulses.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lfsr_d     = lfsr_q;
    gap_sel_d  = gap_sel_q;
    new_pipe_d = 1'b0;
    passed_d   = 1'b0;
    ins_col    = '0;
    ins_tag    = 1'b0;
    if (seed_load) begin
      // An all-zero seed would lock the LFSR, so substitute 1.
      lfsr_d = (seed == 8'h00) ? 8'h01 : seed;
    end else if (adv) begin
      passed_d = tag_q[0];
      if (state_q == SPACE) begin
        if (cnt_q == SPACE_LAST) begin
          cnt_d   = '0;
          state_d = PIPE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          // First column of a pipe picks the opening from the pre-advance LFSR.
          gap_sel_d  = lfsr_q[SEL_W-1:0];
          new_pipe_d = 1'b1;
          lfsr_d     = lfsr_next(lfsr_q);
          ins_col    = pipe_column(lfsr_q[SEL_W-1:0]);
        end else begin
          ins_col    = pipe_column(gap_sel_q);
        end
        if (cnt_q == PIPE_LAST) begin
          ins_tag = 1'b1;
          cnt_d   = '0;
          state_d = SPACE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // FSM, LFSR and registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SPACE;
      cnt_q      <= '0;
      lfsr_q     <= 8'h01;
      gap_sel_q  <= '0;
      new_pipe_q <= 1'b0;
      passed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      gap_sel_q  <= gap_sel_d;
      new_pipe_q <= new_pipe_d;
      passed_q   <= passed_d;
    end
  end

  // Column window: shift toward column 0 and append the new column.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < COLS; i++) begin
        buf_q[i] <= '0;
      end
      tag_q <= '0;
    end else if (adv) begin
      for (int i = 0; i < COLS - 1; i++) begin
        buf_q[i] <= buf_q[i+1];
        tag_q[i] <= tag_q[i+1];
      end
      buf_q[COLS-1] <= ins_col;
      tag_q[COLS-1] <= ins_tag;
    end
  end

  generate
    if ((1 << IDX_W) == COLS) begin : g_rd_full
      assign rd_data = buf_q[rd_col];
    end else begin : g_rd_guard
      // Indices past the last column read as open space.
      always_comb begin
        rd_data = '0;
        if (int'(rd_col) < COLS) begin
          rd_data = buf_q[rd_col];
        end
      end
    end
  endgenerate

  assign front_col = buf_q[0];
  assign gap_sel   = gap_sel_q;
  assign new_pipe  = new_pipe_q;
  assign passed    = passed_q;

endmodule

// File: tb/tb_column_pattern_scroller.sv
// Directed bench for column_pattern_scroller: a default build plus a
// PIPE_W=2 build sharing the same stimulus.
`timescale 1ns/1ps
module tb_column_pattern_scroller;

  logic        clk = 1'b0;
  logic        rst, enable, step, seed_load;
  logic [7:0]  seed;
  logic [2:0]  rd_col;
  logic [15:0] rd_data, front_col, rd_data2, front_col2;
  logic [2:0]  gap_sel, gap_sel2;
  logic        new_pipe, passed, new_pipe2, passed2;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] exp_buf [8];

  always #10 clk = ~clk;

  column_pattern_scroller dut (
    .clk(clk), .rst(rst), .enable(enable), .step(step), .seed_load(seed_load),
    .seed(seed), .rd_col(rd_col), .rd_data(rd_data), .front_col(front_col),
    .gap_sel(gap_sel), .new_pipe(new_pipe), .passed(passed)
  );

  column_pattern_scroller #(.PIPE_W(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .step(step), .seed_load(seed_load),
    .seed(seed), .rd_col(rd_col), .rd_data(rd_data2), .front_col(front_col2),
    .gap_sel(gap_sel2), .new_pipe(new_pipe2), .passed(passed2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cols(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_col = 3'(i);
      #1;
      check($sformatf("%s[%0d]", tag, i), 32'(rd_data), 32'(exp_buf[i]));
    end
    rd_col = 3'd7;
  endtask

  // Three empties then one pipe column; the pipe step also pushes out the previous pipe.
  task automatic run_pipe(input int k0, input logic [15:0] exp_col, input logic [2:0] exp_s);
    step = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (j < 3) begin
        check($sformatf("col%0d", k0 + j), 32'(rd_data), 32'h0);
        check($sformatf("np%0d", k0 + j), 32'(new_pipe), 32'h0);
        check($sformatf("pass%0d", k0 + j), 32'(passed), 32'h0);
      end else begin
        check($sformatf("col%0d", k0 + j), 32'(rd_data), 32'(exp_col));
        check($sformatf("np%0d", k0 + j), 32'(new_pipe), 32'h1);
        check($sformatf("gs%0d", k0 + j), 32'(gap_sel), 32'(exp_s));
        check($sformatf("pass%0d", k0 + j), 32'(passed), 32'h1);
      end
    end
    step = 1'b0;
  endtask

  task automatic load_seed(input logic [7:0] s);
    seed = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; step = 1'b0; seed_load = 1'b0; seed = 8'h00; rd_col = 3'd7;
    tick(); tick();
    rst = 1'b0;

    // Reset state of both builds.
    check("rst_front", 32'(front_col), 32'h0);
    check("rst_gs", 32'(gap_sel), 32'h0);
    check("rst_np", 32'(new_pipe), 32'h0);
    check("rst_pass", 32'(passed), 32'h0);
    check("rst_front2", 32'(front_col2), 32'h0);
    check("rst_gs2", 32'(gap_sel2), 32'h0);
    for (int i = 0; i < 8; i++) exp_buf[i] = 16'h0;
    check_cols("rst_col");

    // Twelve back-to-back steps from reset.
    step = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      case (k)
        1, 2, 3: begin
          check($sformatf("s%0d_col", k), 32'(rd_data), 32'h0);
          check($sformatf("s%0d_np", k), 32'(new_pipe), 32'h0);
        end
        4: begin
          check("s4_col", 32'(rd_data), 32'hFFE1);
          check("s4_np", 32'(new_pipe), 32'h1);
          check("s4_gs", 32'(gap_sel), 32'h1);
        end
        5: check("s5_np", 32'(new_pipe), 32'h0);
        8: begin
          check("s8_col", 32'(rd_data), 32'hFFC3);
          check("s8_np", 32'(new_pipe), 32'h1);
          check("s8_gs", 32'(gap_sel), 32'h2);
          rd_col = 3'd3;
          #1;
          check("s8_col3", 32'(rd_data), 32'hFFE1);
          rd_col = 3'd7;
        end
        11: check("s11_front", 32'(front_col), 32'hFFE1);
        12: begin
          check("s12_pass", 32'(passed), 32'h1);
          check("s12_front", 32'(front_col), 32'h0);
          check("s12_col", 32'(rd_data), 32'hFF0F);
          check("s12_np", 32'(new_pipe), 32'h1);
          check("s12_gs", 32'(gap_sel), 32'h4);
        end
        default: ;
      endcase
      if (k < 12) check($sformatf("s%0d_pass", k), 32'(passed), 32'h0);
    end
    step = 1'b0;
    tick();
    check("idle_np", 32'(new_pipe), 32'h0);
    check("idle_pass", 32'(passed), 32'h0);
    check("idle_gs", 32'(gap_sel), 32'h4);

    exp_buf = '{16'h0, 16'h0, 16'h0, 16'hFFC3, 16'h0, 16'h0, 16'h0, 16'hFF0F};
    check_cols("win12");

    // Step with enable low is dropped.
    enable = 1'b0; step = 1'b1;
    tick();
    enable = 1'b1; step = 1'b0;
    check("enlow_np", 32'(new_pipe), 32'h0);
    check("enlow_pass", 32'(passed), 32'h0);
    check_cols("enlow");

    // Step together with seed_load: seed loads, no shift.
    seed = 8'h05; seed_load = 1'b1; step = 1'b1;
    tick();
    seed_load = 1'b0; step = 1'b0;
    check("seedstep_np", 32'(new_pipe), 32'h0);
    check("seedstep_pass", 32'(passed), 32'h0);
    check_cols("seedstep");

    // Seeded gap positions; rhythm continues from where it held.
    run_pipe(13, 16'hFE1F, 3'd5);
    load_seed(8'h07);
    run_pipe(17, 16'hF87F, 3'd7);
    load_seed(8'h00);
    run_pipe(21, 16'hFFE1, 3'd1);

    // PIPE_W=2 build: reset after the first pipe column.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    step = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    step = 1'b0;
    check("p2_pre_np", 32'(new_pipe2), 32'h1);
    check("p2_pre_col", 32'(rd_data2), 32'hFFE1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("p2_rst_front", 32'(front_col2), 32'h0);
    check("p2_rst_col", 32'(rd_data2), 32'h0);
    check("p2_rst_gs", 32'(gap_sel2), 32'h0);
    check("p2_rst_np", 32'(new_pipe2), 32'h0);
    check("p2_rst_pass", 32'(passed2), 32'h0);

    step = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      check($sformatf("p2_s%0d_pass", k), 32'(passed2), (k == 13) ? 32'h1 : 32'h0);
      case (k)
        3: check("p2_s3_col", 32'(rd_data2), 32'h0);
        4: begin
          check("p2_s4_np", 32'(new_pipe2), 32'h1);
          check("p2_s4_gs", 32'(gap_sel2), 32'h1);
          check("p2_s4_col", 32'(rd_data2), 32'hFFE1);
        end
        5: begin
          check("p2_s5_np", 32'(new_pipe2), 32'h0);
          check("p2_s5_gs", 32'(gap_sel2), 32'h1);
          check("p2_s5_col", 32'(rd_data2), 32'hFFE1);
        end
        6: check("p2_s6_col", 32'(rd_data2), 32'h0);
        12: check("p2_s12_front", 32'(front_col2), 32'hFFE1);
        13: check("p2_s13_front", 32'(front_col2), 32'h0);
        default: ;
      endcase
    end
    step = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/column_pattern_scroller.md
Name: column_pattern_scroller

Overview:
- Next-generation column pattern source for the flappy-bird playfield. Replaces the fixed 3-bit-select → 16-bit combinational column pattern.
- Holds a COLS-deep buffer of ROWS-bit column bitmaps. Each scroll step it shifts the buffer toward column 0 and inserts a new column at the far end.
- A new column is either a pipe (all 1s except a GAP-row opening) or empty (all 0s). Pipe and empty columns come in a programmable rhythm.
- Gap position is taken from an internal seedable LFSR. The block also provides collision data (front column) and a score pulse (passed).

Parameters:
- ROWS, 16: bits per column (display height).
- COLS, 8: columns held in the buffer (display width).
- GAP, 4: height of the pipe opening in rows.
- SEL_W, 3: width of the gap select. Constraint: 2^SEL_W <= ROWS-GAP+1.
- SPACING, 3: empty columns inserted between pipes, >=1.
- PIPE_W, 1: columns per pipe, >=1.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- enable, in, 1: when low, step is ignored.
- step, in, 1: single-cycle scroll request.
- seed_load, in, 1: loads seed into the LFSR.
- seed, in, 8: LFSR seed value.
- rd_col, in, $clog2(COLS): read column index.
- rd_data, out, ROWS: buffer[rd_col], combinational from the registered buffer.
- front_col, out, ROWS: buffer[0], used for collision.
- gap_sel, out, SEL_W: select of the most recently inserted pipe.
- new_pipe, out, 1: one-cycle pulse when the first column of a pipe is inserted.
- passed, out, 1: one-cycle pulse when the last column of a pipe shifts out of column 0.

Behaviour:
- Column encoding:
  - 1 = wall, 0 = open.
  - Pipe column for select s: all ones except bits [s+GAP-1 : s], which are 0.
  - Empty column: all zeros.
- Buffer: each entry is a ROWS-bit bitmap plus a 1-bit pipe_end tag.
- Advance condition: adv = enable & step & ~seed_load.
- On adv, all in one clock edge:
  - buffer[i] <= buffer[i+1] for i < COLS-1.
  - buffer[COLS-1] <= new column.
  - Pulses are registered on the same edge, so they are visible together with the updated buffer.
- LFSR:
  - 8-bit Fibonacci, shifts left; feedback = l[7]^l[5]^l[4]^l[3] enters at bit 0.
  - Reset value 8'h01.
  - seed_load loads seed, except that 8'h00 is replaced by 8'h01.
- Gap selection:
  - On entry to the pipe state, s = lfsr[SEL_W-1:0] (value before the advance), and the LFSR then advances once.
  - All PIPE_W columns of one pipe share s.
- FSM states: SPACE, PIPE. A counter cnt counts columns inserted in the current state.
  - SPACE: inserts an empty column (tag 0) and increments cnt. After the SPACING-th empty column, cnt clears and the FSM goes to PIPE.
  - PIPE: inserts a pipe column. The first column latches s and pulses new_pipe. The PIPE_W-th column sets tag pipe_end=1, clears cnt and returns the FSM to SPACE.
  - The inserted column is decided by the state before the edge.
- passed: pulses on an adv edge whose outgoing buffer[0] has pipe_end=1.
- gap_sel: updates on the new_pipe edge and holds otherwise.
- Reset (overrides every other input), all outputs as follows:
  - Buffer and tags: all 0, so rd_data = front_col = 0.
  - State SPACE, cnt 0, LFSR 8'h01.
  - gap_sel 0, new_pipe 0, passed 0.
- Reset mid-pipe: abandons the pipe; no passed is issued for it.
- enable low: the buffer, FSM, LFSR and pulses all hold; a step is dropped, not queued.
- seed_load together with step: the seed loads and no shift occurs that cycle.
- step held high: one advance per cycle; back-to-back steps are legal.
- rd_col >= COLS (non-power-of-2 COLS): rd_data = 0.

Test Plan:
- Reset, then 4 steps (defaults) → steps 1-3 insert 0x0000; step 4 inserts buffer[7]=16'hFFE1 (s=1), new_pipe=1 and gap_sel=1 on that edge only.
- Continue 4 more steps → step 8 inserts buffer[7]=16'hFFC3 (s=2, LFSR 01→02→04); pipe 1 is then at buffer[3].
- From reset, 12 steps → pipe 1 reaches front_col=16'hFFE1 after step 11; passed pulses exactly on step 12; front_col is then 0x0000.
- Patterns: seed_load with seed=8'h05, then a pipe insert → 16'hFE1F (s=5). With seed=8'h07 → 16'hF87F. With seed=8'h00 → LFSR holds 8'h01, giving s=1.
- Step with enable=0, and step together with seed_load → buffer, counters and pulses unchanged; rd_data at all 8 columns is identical before and after.
- rst asserted mid-pipe with PIPE_W=2 build (after the first pipe column) → next cycle all outputs are zero; no passed ever fires for that pipe; the first new pipe again appears after 3 empties with s=1.
